rc_loader: RTL and testbench

//  Runtime counterpart of the file-based seed reader for the Toeplitz hash. Accepts first-row and

---
 rtl/rc_loader.sv | 124 ++++++++++++
 tb/tb_rc_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc_loader.sv
// Runtime seed loader for the Toeplitz hash: collects column then row seed words from a
// valid/ready stream and commits rrow0/col0 atomically in the same format as the file-based path.
module rc_loader #(
  parameter int BS = 64,
  parameter int N  = 256,
  parameter int L  = 128
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [BS-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          rc_valid,
  output logic          done,
  output logic [N-1:0]  rrow0,
  output logic [L-1:0]  col0,
  output logic [1:0]    dbg_state
);

  localparam int XSZ = N / BS;
  localparam int YSZ = L / BS;
  localparam int NW  = XSZ + YSZ;
  localparam int CW  = $clog2(NW + 1);

  if ((N % BS) != 0) begin : g_bad_n
    $error("rc_loader: N must be a multiple of BS");
  end
  if ((L % BS) != 0) begin : g_bad_l
    $error("rc_loader: L must be a multiple of BS");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COL  = 2'd1,
    S_ROW  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [L-1:0]    col_stg;
  logic [N-1:0]    row_stg;
  logic [L+BS-1:0] col_cat;
  logic [N+BS-1:0] row_cat;
  logic [N-1:0]    row_shift;
  logic [N-1:0]    row_rev;
  logic            hs;
  logic            col_last;
  logic            commit;

  // Handshake: a word transfers on a rising edge where in_valid & in_ready are both high.
  // in_ready is decoded from state only; a start in the same cycle wins and drops the word.
  assign in_ready  = (state == S_COL) || (state == S_ROW);
  assign busy      = in_ready;
  assign dbg_state = state;

  assign hs       = in_valid && in_ready && !start;
  assign col_last = (state == S_COL) && hs && (cnt == CW'(YSZ - 1));
  assign commit   = (state == S_ROW) && hs && (cnt == CW'(XSZ - 1));

  // Shifting left by one word keeps the first word received in the MSBs.
  assign col_cat = {col_stg, in_data};
  assign row_cat = {row_stg, in_data};

  always_comb begin
    row_rev   = '0;
    row_shift = {row_cat[N-2:0], 1'b0};
    for (int i = 0; i < N; i++) begin
      row_rev[i] = row_shift[N-1-i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_COL;
      S_COL: begin
        if (start)         state_nxt = S_COL;
        else if (col_last) state_nxt = S_ROW;
      end
      S_ROW: begin
        if (start)       state_nxt = S_COL;
        else if (commit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      col_stg  <= '0;
      row_stg  <= '0;
      rrow0    <= '0;
      col0     <= '0;
      rc_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= commit;
      if (start) begin
        cnt     <= '0;
        col_stg <= '0;
        row_stg <= '0;
      end else if (hs) begin
        if (col_last || commit) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
        if (state == S_COL) col_stg <= col_cat[L-1:0];
        else                row_stg <= row_cat[N-1:0];
      end
      if (commit) begin
        col0     <= col_stg;
        rrow0    <= row_rev;
        rc_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rc_loader.sv
// Directed-plus-random bench for rc_loader; expected seeds come from a word-level model
// of the stream format and are queued until the matching done pulse.
module tb_rc_loader;

  localparam int BS = 64;
  localparam int N  = 256;
  localparam int L  = 128;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [BS-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, busy, rc_valid, done;
  logic [N-1:0]  rrow0;
  logic [L-1:0]  col0;
  logic [1:0]    dbg_state;

  rc_loader #(.BS(BS), .N(N), .L(L)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .rc_valid(rc_valid), .done(done),
    .rrow0(rrow0), .col0(col0), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rdy_cnt = 0;
  int rc_drop = 0;
  bit watch_rc = 1'b0;

  logic [N+L-1:0] exp_q[$];
  logic [BS-1:0]  w[NW];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (in_ready) rdy_cnt++;
    if (watch_rc && !rc_valid) rc_drop++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: col0 is c-words concatenated; rrow0 is the bit-reverse of the
  // concatenated row words shifted left by one.
  function automatic logic [N+L-1:0] model();
    logic [L-1:0] c;
    logic [N-1:0] r;
    logic [N-1:0] rev;
    c   = {w[0], w[1]};
    r   = {w[2], w[3], w[4], w[5]};
    r   = r << 1;
    rev = {<<{r}};
    return {rev, c};
  endfunction

  task automatic rand_words();
    for (int i = 0; i < NW; i++) w[i] = {$urandom, $urandom};
  endtask

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int first, input int last, input int duty);
    int  idx;
    int  guard;
    bit  hs;
    idx   = first;
    guard = 0;
    while (idx < last && guard < 500) begin
      in_valid = ($urandom_range(99) < duty);
      in_data  = w[idx];
      hs       = in_valid && in_ready;
      tick();
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 500) check("send_timeout", 256'(idx), 256'(last));
  endtask

  task automatic finish_commit();
    logic [N+L-1:0] e;
    check("done_pulse", 256'(done), 256'(1));
    e = exp_q.pop_front();
    check("rrow0", rrow0, e[N+L-1:L]);
    check("col0", 256'(col0), 256'(e[L-1:0]));
    check("rc_valid", 256'(rc_valid), 256'(1));
  endtask

  task automatic full_load(input int duty);
    exp_q.push_back(model());
    pulse_start();
    send_words(0, NW, duty);
    finish_commit();
  endtask

  initial begin
    logic [N-1:0] k;
    logic [N+L-1:0] seed_a;

    repeat (3) tick();
    check("rst_rrow0", rrow0, '0);
    check("rst_col0", 256'(col0), '0);
    check("rst_rc_valid", 256'(rc_valid), '0);
    check("rst_done", 256'(done), '0);
    check("rst_in_ready", 256'(in_ready), '0);
    check("rst_busy", 256'(busy), '0);
    rstn = 1'b1;
    tick();

    // words offered while idle are refused
    in_valid = 1'b1;
    in_data  = '1;
    repeat (3) tick();
    check("idle_in_ready", 256'(in_ready), '0);
    in_valid = 1'b0;

    // scenario 1: back-to-back
    w = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h0, 64'h0, 64'h0, 64'h0};
    done_cnt = 0;
    rdy_cnt  = 0;
    full_load(100);
    check("s1_ready_cycles", 256'(rdy_cnt), 256'(6));
    check("s1_col0_const", 256'(col0), 256'({64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}));
    check("s1_rrow0_const", rrow0, '0);
    tick();
    check("s1_done_low", 256'(done), '0);
    check("s1_done_count", 256'(done_cnt), 256'(1));
    check("s1_busy_after", 256'(busy), '0);

    // scenario 2: shift-in and LSB boundary bits
    w = '{64'h0, 64'h0, 64'h4000_0000_0000_0000, 64'h0, 64'h0, 64'h1};
    full_load(100);
    k = '0;
    k[0]   = 1'b1;
    k[254] = 1'b1;
    check("s2_rrow0_const", rrow0, k);
    check("s2_rrow0_msb", 256'(rrow0[N-1]), '0);

    // scenario 3: MSB shifted out
    w = '{64'h0, 64'h0, 64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0};
    full_load(100);
    check("s3_rrow0_zero", rrow0, '0);

    // scenario 4: valid gaps
    w = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h0, 64'h0, 64'h0, 64'h0};
    tick();
    done_cnt = 0;
    full_load(50);
    tick();
    tick();
    check("s4_done_count", 256'(done_cnt), 256'(1));

    // scenario 5: abort mid-load keeps seed A until seed B commits
    watch_rc = 1'b1;
    rand_words();
    seed_a = model();
    full_load(100);
    done_cnt = 0;
    rand_words();
    pulse_start();
    send_words(0, 3, 100);
    check("s5_hold_rrow0", rrow0, seed_a[N+L-1:L]);
    check("s5_hold_col0", 256'(col0), 256'(seed_a[L-1:0]));
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    rand_words();
    exp_q.push_back(model());
    send_words(0, NW, 70);
    finish_commit();
    tick();
    check("s5_done_count", 256'(done_cnt), 256'(1));
    check("s5_rc_drop", 256'(rc_drop), '0);
    watch_rc = 1'b0;

    // random loads, each start issued in the cycle after the previous commit
    for (int n = 0; n < 4; n++) begin
      rand_words();
      full_load(int'($urandom_range(100, 30)));
    end

    // scenario 6: reset mid-load
    rand_words();
    pulse_start();
    send_words(0, 4, 100);
    rstn = 1'b0;
    #1;
    check("s6_rrow0", rrow0, '0);
    check("s6_col0", 256'(col0), '0);
    check("s6_rc_valid", 256'(rc_valid), '0);
    check("s6_in_ready", 256'(in_ready), '0);
    tick();
    rstn     = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    check("s6_ready_idle", 256'(in_ready), '0);
    in_valid = 1'b0;
    rand_words();
    full_load(80);

    check("queue_empty", 256'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
